// File: rtl/input_logic_if.sv
// Ingress link bundle: sender req/ack word path plus the per-port FIFO write side.
// slave  = input_logic (the router ingress block)
// master = the environment driving words and reporting FIFO fullness
interface input_logic_if #(
  parameter int DATA_W  = 8,
  parameter int N_PORTS = 3
) ();
  logic [DATA_W-1:0]  data_in;
  logic               data_in_req;
  logic               data_in_ack;
  logic [N_PORTS-1:0] fifo_full;
  logic [N_PORTS-1:0] fifo_push;
  logic [DATA_W-1:0]  fifo_data;

  modport slave (
    input  data_in, data_in_req, fifo_full,
    output data_in_ack, fifo_push, fifo_data
  );

  modport master (
    output data_in, data_in_req, fifo_full,
    input  data_in_ack, fifo_push, fifo_data
  );
endinterface

// File: rtl/input_logic.sv
// Router ingress: parses a header word (dest, len), steers the header and its
// payload words into the destination FIFO with zero latency, and silently
// swallows packets addressed to a nonexistent port.
// Optional macro INPUT_LOGIC_DROP_CNT_EN enables a saturating dropped-packet
// counter on drop_cnt; without it drop_cnt is tied to zero.
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | next word is a header
// S_PAYLOAD | forwarding payload words to dest_q, rem_cnt_q left
// S_DROP    | discarding payload of an invalid-dest packet
module input_logic #(
  parameter int DATA_W  = 8,
  parameter int N_PORTS = 3,
  parameter int LEN_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input_logic_if.slave        bus,
  output logic                pkt_drop,
  output logic [7:0]          drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  rem_cnt_q;
  logic [1:0]        dest_q;
  logic              pkt_drop_q;

  logic [1:0]        hdr_dest;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_valid;
  logic [3:0]        full_pad;
  logic [3:0]        push_pad;
  logic              ack;
  logic              xfer;

  assign hdr_dest  = bus.data_in[DATA_W-1:DATA_W-2];
  assign hdr_len   = bus.data_in[LEN_W-1:0];
  assign hdr_valid = ({1'b0, hdr_dest} < 3'(N_PORTS));

  // Pad the full flags to the 4-port header space so any dest indexes safely.
  always_comb begin
    full_pad = 4'b0000;
    full_pad[N_PORTS-1:0] = bus.fifo_full;
  end

  // Combinational handshake and one-hot push steering; forced idle in reset.
  always_comb begin
    ack      = 1'b0;
    push_pad = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (hdr_valid) begin
          ack = bus.data_in_req && !full_pad[hdr_dest];
          push_pad[hdr_dest] = ack;
        end else begin
          ack = bus.data_in_req;
        end
      end
      S_PAYLOAD: begin
        ack = bus.data_in_req && !full_pad[dest_q];
        push_pad[dest_q] = ack;
      end
      S_DROP: begin
        ack = bus.data_in_req;
      end
      default: begin
        ack      = 1'b0;
        push_pad = 4'b0000;
      end
    endcase
    if (!rst_n) begin
      ack      = 1'b0;
      push_pad = 4'b0000;
    end
  end

  assign xfer            = bus.data_in_req && ack;
  assign bus.data_in_ack = ack;
  assign bus.fifo_push   = push_pad[N_PORTS-1:0];
  assign bus.fifo_data   = bus.data_in;
  assign pkt_drop        = pkt_drop_q;

  // Packet FSM: header parse, payload word countdown, drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rem_cnt_q  <= '0;
      dest_q     <= 2'd0;
      pkt_drop_q <= 1'b0;
    end else begin
      pkt_drop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            rem_cnt_q <= hdr_len;
            if (hdr_valid) begin
              dest_q  <= hdr_dest;
              state_q <= (hdr_len != '0) ? S_PAYLOAD : S_IDLE;
            end else begin
              pkt_drop_q <= 1'b1;
              state_q    <= (hdr_len != '0) ? S_DROP : S_IDLE;
            end
          end
        end
        S_PAYLOAD, S_DROP: begin
          if (xfer) begin
            rem_cnt_q <= rem_cnt_q - LEN_W'(1);
            if (rem_cnt_q == LEN_W'(1)) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef INPUT_LOGIC_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating count of dropped packets, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                drop_cnt_q <= 8'd0;
    else if (pkt_drop_q && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_input_logic.sv
// Directed bench for input_logic: a stream table of header/payload vectors,
// then hand sequences for backpressure, mid-packet reset and drop counting.
module tb_input_logic;

  logic       clk;
  logic       rst_n;
  logic       pkt_drop;
  logic [7:0] drop_cnt;

  input_logic_if #(.DATA_W(8), .N_PORTS(3)) bus ();

  input_logic #(.DATA_W(8), .N_PORTS(3), .LEN_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .pkt_drop (pkt_drop),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef INPUT_LOGIC_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Observed pushes as {port, data}, captured at the transfer edge.
  logic [9:0] pushed[$];
  always @(posedge clk) begin
    for (int p = 0; p < 3; p++)
      if (bus.fifo_push[p]) pushed.push_back({p[1:0], bus.fifo_data});
  end

  typedef struct {
    logic       req;
    logic [7:0] d;
    logic [2:0] full;
    logic       ack;
    logic [2:0] push;
    logic       drop;
  } vec_t;

  vec_t tbl[16];

  task automatic apply(input logic req, input logic [7:0] d, input logic [2:0] full,
                       input logic eack, input logic [2:0] epush, input logic edrop,
                       input string name);
    @(negedge clk);
    bus.data_in_req = req;
    bus.data_in     = d;
    bus.fifo_full   = full;
    #1;
    n_vec++;
    if (bus.data_in_ack !== eack || bus.fifo_push !== epush || pkt_drop !== edrop ||
        bus.fifo_data !== d) begin
      n_bad++;
      $display("FAIL %s: got ack=%b push=%b drop=%b data=%h, expected ack=%b push=%b drop=%b data=%h",
               name, bus.data_in_ack, bus.fifo_push, pkt_drop, bus.fifo_data,
               eack, epush, edrop, d);
    end
  endtask

  task automatic check_cnt(input logic [7:0] exp, input string name);
    n_vec++;
    if (drop_cnt !== exp) begin
      n_bad++;
      $display("FAIL %s: drop_cnt=%0d expected %0d", name, drop_cnt, exp);
    end
  endtask

  logic [9:0] exp_q[$];

  initial begin
    // Stream: plan items 1-3 back to back, then cross-port blocking checks.
    tbl[0]  = '{1'b1, 8'h42, 3'b000, 1'b1, 3'b010, 1'b0};
    tbl[1]  = '{1'b1, 8'hAA, 3'b000, 1'b1, 3'b010, 1'b0};
    tbl[2]  = '{1'b1, 8'hBB, 3'b000, 1'b1, 3'b010, 1'b0};
    tbl[3]  = '{1'b1, 8'h00, 3'b000, 1'b1, 3'b001, 1'b0};
    tbl[4]  = '{1'b1, 8'h81, 3'b000, 1'b1, 3'b100, 1'b0};
    tbl[5]  = '{1'b1, 8'h5C, 3'b000, 1'b1, 3'b100, 1'b0};
    tbl[6]  = '{1'b1, 8'hC3, 3'b000, 1'b1, 3'b000, 1'b0};
    tbl[7]  = '{1'b1, 8'h11, 3'b000, 1'b1, 3'b000, 1'b1};
    tbl[8]  = '{1'b1, 8'h22, 3'b000, 1'b1, 3'b000, 1'b0};
    tbl[9]  = '{1'b1, 8'h33, 3'b000, 1'b1, 3'b000, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0};
    tbl[11] = '{1'b1, 8'h40, 3'b010, 1'b0, 3'b000, 1'b0};
    tbl[12] = '{1'b1, 8'h40, 3'b010, 1'b0, 3'b000, 1'b0};
    tbl[13] = '{1'b1, 8'h40, 3'b000, 1'b1, 3'b010, 1'b0};
    tbl[14] = '{1'b1, 8'h00, 3'b010, 1'b1, 3'b001, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0};

    rst_n           = 1'b0;
    bus.data_in_req = 1'b1;
    bus.data_in     = 8'h42;
    bus.fifo_full   = 3'b000;
    #12;
    n_vec++;
    if (bus.data_in_ack !== 1'b0 || bus.fifo_push !== 3'b000 || pkt_drop !== 1'b0 ||
        drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset: ack=%b push=%b drop=%b cnt=%0d expected all zero",
               bus.data_in_ack, bus.fifo_push, pkt_drop, drop_cnt);
    end
    @(negedge clk);
    bus.data_in_req = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      apply(tbl[i].req, tbl[i].d, tbl[i].full, tbl[i].ack, tbl[i].push, tbl[i].drop,
            $sformatf("table[%0d]", i));
    check_cnt(CNT_EN ? 8'd1 : 8'd0, "drop_cnt_after_one_drop");

    // Backpressure: dest 1 len 4, port 1 full for 3 cycles after 2nd payload word.
    pushed.delete();
    apply(1'b1, 8'h44, 3'b000, 1'b1, 3'b010, 1'b0, "bp_hdr");
    apply(1'b1, 8'hA1, 3'b000, 1'b1, 3'b010, 1'b0, "bp_w1");
    apply(1'b1, 8'hA2, 3'b000, 1'b1, 3'b010, 1'b0, "bp_w2");
    for (int i = 0; i < 3; i++)
      apply(1'b1, 8'hA3, 3'b010, 1'b0, 3'b000, 1'b0, $sformatf("bp_stall%0d", i));
    apply(1'b1, 8'hA3, 3'b000, 1'b1, 3'b010, 1'b0, "bp_w3");
    apply(1'b1, 8'hA4, 3'b000, 1'b1, 3'b010, 1'b0, "bp_w4");
    apply(1'b1, 8'h00, 3'b000, 1'b1, 3'b001, 1'b0, "bp_next_hdr");
    apply(1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, "bp_idle");
    exp_q = '{{2'd1, 8'h44}, {2'd1, 8'hA1}, {2'd1, 8'hA2}, {2'd1, 8'hA3},
              {2'd1, 8'hA4}, {2'd0, 8'h00}};
    n_vec++;
    if (pushed.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL bp_push_count: got %0d pushes expected %0d", pushed.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (pushed[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL bp_push[%0d]: got %h expected %h", i, pushed[i], exp_q[i]);
        end
      end
    end

    // Reset after 1 of 3 payload words of a dest-1 packet.
    apply(1'b1, 8'h43, 3'b000, 1'b1, 3'b010, 1'b0, "rst_hdr");
    apply(1'b1, 8'h11, 3'b000, 1'b1, 3'b010, 1'b0, "rst_w1");
    @(negedge clk);
    rst_n = 1'b0;
    bus.data_in = 8'h22;
    #1;
    n_vec++;
    if (bus.data_in_ack !== 1'b0 || bus.fifo_push !== 3'b000 || drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL mid_reset: ack=%b push=%b cnt=%0d expected 0 000 0",
               bus.data_in_ack, bus.fifo_push, drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 8'h01, 3'b000, 1'b1, 3'b001, 1'b0, "post_rst_hdr");
    apply(1'b1, 8'h77, 3'b000, 1'b1, 3'b001, 1'b0, "post_rst_w");
    apply(1'b1, 8'h81, 3'b000, 1'b1, 3'b100, 1'b0, "post_rst_hdr2");
    apply(1'b1, 8'h5D, 3'b000, 1'b1, 3'b100, 1'b0, "post_rst_w2");

    // 300 zero-length invalid-dest packets back to back.
    for (int i = 0; i < 300; i++)
      apply(1'b1, 8'hC0, 3'b000, 1'b1, 3'b000, (i > 0), $sformatf("drop%0d", i));
    apply(1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b1, "drop_last_pulse");
    apply(1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, "drop_quiet");
    check_cnt(CNT_EN ? 8'd255 : 8'd0, "drop_cnt_saturate");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
